instruction_fetch: RTL and testbench

Upstream fetch stage for the single-cycle MIPS datapath. Holds the architectural PC, requests instruction words from instruction memory over a req/ack handshake, and presents each word to the decoder with a valid/ready handshake. When the core accepts a word, it computes the next PC from the core's PC-select inputs (sequential, branch, jump, jump-register). Misaligned targets are trapped in a sticky error state.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_next_pc.sv | 28 ++
 rtl/instruction_fetch.sv | 87 ++++++++
 tb/tb_instruction_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: PC-select and fetch-state encodings, reset PC.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned JADDR_W = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_VALID = 2'd2,
        FS_ERR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection (sequential, branch, jump, jump-register), mod 2^32.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]    pc,
    input  logic [1:0]         pc_sel,
    input  logic [XLEN-1:0]    branch_imm,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic [XLEN-1:0]    reg_rs,
    output logic [XLEN-1:0]    next_pc
);

    logic [XLEN-1:0] pc4;

    assign pc4 = pc + XLEN'(4);

    always_comb begin
        next_pc = pc4;
        case (pc_sel_e'(pc_sel))
            PC_SEQ: next_pc = pc4;
            PC_BR:  next_pc = pc4 + (branch_imm << 2);
            PC_J:   next_pc = {pc4[31:28], jump_addr, 2'b00};
            PC_JR:  next_pc = reg_rs;
            default: next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word at a time over req/ack, hands it to the
// decoder over valid/ready, and traps misaligned targets in a sticky error state.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [XLEN-1:0]    pc,
    input  logic [1:0]         pc_sel,
    input  logic [XLEN-1:0]    branch_imm,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic [XLEN-1:0]    reg_rs,
    output logic [XLEN-1:0]    instr_count,
    output logic               fetch_err
);

    fetch_state_e    state;
    logic [XLEN-1:0] next_pc;

    fetch_next_pc u_next_pc (
        .pc         (pc),
        .pc_sel     (pc_sel),
        .branch_imm (branch_imm),
        .jump_addr  (jump_addr),
        .reg_rs     (reg_rs),
        .next_pc    (next_pc)
    );

    // The address bus is the PC register itself; it only matters while imem_req is high.
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            instr_count <= '0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                FS_IDLE: begin
                    state    <= FS_FETCH;
                    imem_req <= 1'b1;
                end
                FS_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= FS_VALID;
                    end
                end
                FS_VALID: begin
                    if (instr_ready) begin
                        instr_count <= instr_count + XLEN'(1);
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] == 2'b00) begin
                            imem_req <= 1'b1;
                            state    <= FS_FETCH;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= FS_ERR;
                        end
                    end
                end
                FS_ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= FS_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory and core are driven step by step at the falling edge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic [31:0] branch_imm;
    logic [25:0] jump_addr;
    logic [31:0] reg_rs;
    logic [31:0] instr_count;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_sel      (pc_sel),
        .branch_imm  (branch_imm),
        .jump_addr   (jump_addr),
        .reg_rs      (reg_rs),
        .instr_count (instr_count),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // In FETCH: return one word with zero wait, land in VALID at the next falling edge.
    task automatic give_word(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    // In VALID: accept the word with the given PC-select inputs.
    task automatic accept(input logic [1:0] sel, input logic [31:0] imm,
                          input logic [25:0] ja, input logic [31:0] rs);
        pc_sel      = sel;
        branch_imm  = imm;
        jump_addr   = ja;
        reg_rs      = rs;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_sel      = 2'd0;
        branch_imm  = 32'h0;
        jump_addr   = 26'h0;
        reg_rs      = 32'h0;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        pc_sel      = 2'd0;
        branch_imm  = 32'h0;
        jump_addr   = 26'h0;
        reg_rs      = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_pc",    pc,               32'h0);
        chk("rst_instr", instr,            32'h0);
        chk("rst_cnt",   instr_count,      32'h0);
        chk("rst_err",   32'(fetch_err),   32'h0);

        // Release reset; imem_req rises one edge later.
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'h1);

        // Zero-wait sequential stream, core always ready.
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("seq_addr%0d", k), imem_addr, 32'(4 * k));
            chk($sformatf("seq_req%0d", k), 32'(imem_req), 32'h1);
            imem_ack   = 1'b1;
            imem_rdata = 32'h1000_0000 + 32'(k);
            @(negedge clk);
            imem_ack   = 1'b0;
            chk($sformatf("seq_valid%0d", k), 32'(instr_valid), 32'h1);
            chk($sformatf("seq_novreq%0d", k), 32'(imem_req), 32'h0);
            chk($sformatf("seq_instr%0d", k), instr, 32'h1000_0000 + 32'(k));
            @(negedge clk);
        end
        instr_ready = 1'b0;
        chk("seq_cnt4", instr_count, 32'd4);
        chk("seq_addr4", imem_addr, 32'h10);

        // Memory wait states: request and address held until ack.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("wait_req%0d", k), 32'(imem_req), 32'h1);
            chk($sformatf("wait_addr%0d", k), imem_addr, 32'h10);
            chk($sformatf("wait_valid%0d", k), 32'(instr_valid), 32'h0);
        end
        give_word(32'hDEAD_BEEF);
        chk("wait_valid", 32'(instr_valid), 32'h1);
        chk("wait_instr", instr, 32'hDEAD_BEEF);

        // Backpressure: word and PC held, no request.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k), 32'(instr_valid), 32'h1);
            chk($sformatf("bp_instr%0d", k), instr, 32'hDEAD_BEEF);
            chk($sformatf("bp_pc%0d", k), pc, 32'h10);
            chk($sformatf("bp_req%0d", k), 32'(imem_req), 32'h0);
        end

        // Branch backwards from 0x100: 0x104 + (-2 << 2) = 0xFC.
        accept(2'd3, 32'h0, 26'h0, 32'h0000_0100);
        chk("jr100_addr", imem_addr, 32'h100);
        give_word(32'h1111_1111);
        accept(2'd1, 32'hFFFF_FFFE, 26'h0, 32'h0);
        chk("br_addr", imem_addr, 32'h0000_00FC);
        chk("br_req", 32'(imem_req), 32'h1);
        chk("br_cnt", instr_count, 32'd6);

        // Jump from 0x0040_0010: {0x0, 0x40, 00} = 0x100.
        give_word(32'h2222_2222);
        accept(2'd3, 32'h0, 26'h0, 32'h0040_0010);
        chk("jr_400010", imem_addr, 32'h0040_0010);
        give_word(32'h3333_3333);
        accept(2'd2, 32'h0, 26'h000_0040, 32'h0);
        chk("j_addr", imem_addr, 32'h0000_0100);

        // PC wraparound on sequential increment.
        give_word(32'h4444_4444);
        accept(2'd3, 32'h0, 26'h0, 32'hFFFF_FFFC);
        chk("jr_top", imem_addr, 32'hFFFF_FFFC);
        give_word(32'h5555_5555);
        accept(2'd0, 32'h0, 26'h0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Aligned jr, then misaligned jr into the sticky error state.
        give_word(32'h6666_6666);
        accept(2'd3, 32'h0, 26'h0, 32'h0000_2000);
        chk("jr_addr", imem_addr, 32'h2000);
        give_word(32'h7777_7777);
        accept(2'd3, 32'h0, 26'h0, 32'h0000_2002);
        chk("err_flag", 32'(fetch_err), 32'h1);
        chk("err_pc", pc, 32'h2002);
        chk("err_cnt", instr_count, 32'd12);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("err_req%0d", k), 32'(imem_req), 32'h0);
            chk($sformatf("err_valid%0d", k), 32'(instr_valid), 32'h0);
            chk($sformatf("err_sticky%0d", k), 32'(fetch_err), 32'h1);
            chk($sformatf("err_pchold%0d", k), pc, 32'h2002);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;

        // Reset clears the error; then move PC away from RESET_PC.
        rst_n = 1'b0;
        @(negedge clk);
        chk("rerst_err", 32'(fetch_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst_addr", imem_addr, 32'h0);
        give_word(32'h8888_8888);
        accept(2'd3, 32'h0, 26'h0, 32'h0000_0300);
        chk("pre_arst_addr", imem_addr, 32'h300);
        chk("pre_arst_req", 32'(imem_req), 32'h1);

        // Asynchronous reset in FETCH with ack pending takes effect before any edge.
        imem_ack = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_cnt", instr_count, 32'h0);
        chk("arst_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("arst_instr", instr, 32'h0);
        imem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
